// File: rtl/full_adder_data_if.sv
// full_adder_data_if: operand/result bundle for the registered ripple-carry adder.
interface full_adder_data_if #(parameter int WIDTH = 1, parameter int CNT_W = 16);
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Cin;
  logic             in_valid;
  logic [WIDTH-1:0] S;
  logic             Cout;
  logic             out_valid;
  logic             OVF;
  logic             ZERO;
  logic [CNT_W-1:0] carry_cnt;
  modport master (output A, B, Cin, in_valid, input S, Cout, out_valid, OVF, ZERO, carry_cnt);
  modport slave  (input A, B, Cin, in_valid, output S, Cout, out_valid, OVF, ZERO, carry_cnt);
endinterface

// File: rtl/full_adder_data.sv
// full_adder_data: registered ripple-carry adder of full-adder cells with
// valid strobe, OVF/ZERO flags and a saturating carry-out event counter.
module full_adder_data #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  full_adder_data_if.slave bus
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_d, s_q;
  logic             cout_d, cout_q, ovf_d, ovf_q, zero_d, zero_q, valid_d, valid_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  assign c[0] = bus.Cin;
  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    assign s[i]   = bus.A[i] ^ bus.B[i] ^ c[i];
    assign c[i+1] = (bus.A[i] & bus.B[i]) | (c[i] & (bus.A[i] ^ bus.B[i]));
  end
  always_comb begin
    s_d     = bus.in_valid ? s : s_q;
    cout_d  = bus.in_valid ? c[WIDTH] : cout_q;
    ovf_d   = bus.in_valid ? c[WIDTH] ^ c[WIDTH-1] : ovf_q;
    zero_d  = bus.in_valid ? ~|s : zero_q;
    valid_d = bus.in_valid;
    // counter holds at all-ones instead of wrapping
    cnt_d   = (bus.in_valid && c[WIDTH] && !(&cnt_q)) ? cnt_q + CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q     <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b1;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      s_q     <= s_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end
  assign bus.S         = s_q;
  assign bus.Cout      = cout_q;
  assign bus.OVF       = ovf_q;
  assign bus.ZERO      = zero_q;
  assign bus.out_valid = valid_q;
  assign bus.carry_cnt = cnt_q;
endmodule

// File: tb/tb_full_adder_data.sv
// tb_full_adder_data: scoreboard bench over three adder instances
// (1-bit, 8-bit, 1-bit with a 2-bit counter).
module tb_full_adder_data;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  full_adder_data_if #(.WIDTH(1), .CNT_W(16)) b1 ();
  full_adder_data_if #(.WIDTH(8), .CNT_W(16)) b8 ();
  full_adder_data_if #(.WIDTH(1), .CNT_W(2))  bs ();

  full_adder_data #(.WIDTH(1), .CNT_W(16)) u_d1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  full_adder_data #(.WIDTH(8), .CNT_W(16)) u_d8 (.clk(clk), .rst_n(rst_n), .bus(b8.slave));
  full_adder_data #(.WIDTH(1), .CNT_W(2))  u_ds (.clk(clk), .rst_n(rst_n), .bus(bs.slave));

  typedef struct packed {
    logic [63:0] s;
    logic        c;
    logic        ovf;
    logic        zero;
    logic [15:0] cnt;
  } exp_t;

  exp_t q [3][$];
  exp_t last [3];
  int   m_cnt [3];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      q[d].delete();
      last[d] = '{s: 64'd0, c: 1'b0, ovf: 1'b0, zero: 1'b1, cnt: 16'd0};
      m_cnt[d] = 0;
    end
  endtask

  task automatic drive(input int d, input logic [7:0] a, input logic [7:0] b, input logic ci, input logic v);
    exp_t e;
    logic [8:0] sum;
    int w, cmax;
    w = (d == 1) ? 8 : 1;
    cmax = (d == 2) ? 3 : 65535;
    case (d)
      0: begin b1.A = a[0]; b1.B = b[0]; b1.Cin = ci; b1.in_valid = v; end
      1: begin b8.A = a;    b8.B = b;    b8.Cin = ci; b8.in_valid = v; end
      default: begin bs.A = a[0]; bs.B = b[0]; bs.Cin = ci; bs.in_valid = v; end
    endcase
    if (v && rst_n) begin
      sum = (w == 8) ? {1'b0, a} + {1'b0, b} + 9'(ci) : {8'd0, a[0]} + {8'd0, b[0]} + 9'(ci);
      e.s = (w == 8) ? 64'(sum[7:0]) : 64'(sum[0]);
      e.c = sum[w];
      e.ovf = e.c ^ (sum[w-1] ^ a[w-1] ^ b[w-1]);
      e.zero = (e.s == 64'd0);
      if (e.c && m_cnt[d] != cmax) m_cnt[d]++;
      e.cnt = 16'(m_cnt[d]);
      q[d].push_back(e);
    end
  endtask

  task automatic mon(input int d, input string tag);
    logic ov, c, o, z;
    logic [63:0] s;
    logic [15:0] n;
    logic pend;
    case (d)
      0: begin ov = b1.out_valid; s = 64'(b1.S); c = b1.Cout; o = b1.OVF; z = b1.ZERO; n = 16'(b1.carry_cnt); end
      1: begin ov = b8.out_valid; s = 64'(b8.S); c = b8.Cout; o = b8.OVF; z = b8.ZERO; n = 16'(b8.carry_cnt); end
      default: begin ov = bs.out_valid; s = 64'(bs.S); c = bs.Cout; o = bs.OVF; z = bs.ZERO; n = 16'(bs.carry_cnt); end
    endcase
    pend = (q[d].size() != 0);
    chk($sformatf("%s.d%0d.out_valid", tag, d), 64'(ov), 64'(pend));
    if (pend) last[d] = q[d].pop_front();
    chk($sformatf("%s.d%0d.S", tag, d), s, last[d].s);
    chk($sformatf("%s.d%0d.Cout", tag, d), 64'(c), 64'(last[d].c));
    chk($sformatf("%s.d%0d.OVF", tag, d), 64'(o), 64'(last[d].ovf));
    chk($sformatf("%s.d%0d.ZERO", tag, d), 64'(z), 64'(last[d].zero));
    chk($sformatf("%s.d%0d.carry_cnt", tag, d), 64'(n), 64'(last[d].cnt));
  endtask

  task automatic step(input string tag);
    logic r;
    r = rst_n;
    @(posedge clk);
    #1;
    if (!r) model_reset();
    for (int d = 0; d < 3; d++) mon(d, tag);
  endtask

  task automatic cyc(input string tag, input int d, input logic [7:0] a, input logic [7:0] b, input logic ci, input logic v);
    for (int k = 0; k < 3; k++)
      if (k == d) drive(k, a, b, ci, v);
      else drive(k, 8'd0, 8'd0, 1'b0, 1'b0);
    step(tag);
  endtask

  logic [2:0] tt [8] = '{3'b000, 3'b100, 3'b010, 3'b110, 3'b001, 3'b101, 3'b011, 3'b111};

  initial begin
    model_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      for (int d = 0; d < 3; d++) drive(d, 8'd1, 8'd1, 1'b1, 1'b1);
      step("rst");
    end
    chk("rst.ZERO", 64'(b1.ZERO), 64'd1);
    chk("rst.cnt", 64'(b8.carry_cnt), 64'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      logic [2:0] v;
      v = tt[i];
      cyc("tt", 0, 8'(v[2]), 8'(v[1]), v[0], 1'b1);
    end
    chk("tt.final_cnt", 64'(b1.carry_cnt), 64'd4);

    for (int i = 0; i < 3; i++)
      cyc("hold", 0, 8'($urandom), 8'($urandom), 1'($urandom), 1'b0);
    chk("hold.cnt", 64'(b1.carry_cnt), 64'd4);

    cyc("w8_ff", 1, 8'hFF, 8'h00, 1'b1, 1'b1);
    chk("w8_ff.ZERO", 64'(b8.ZERO), 64'd1);
    cyc("w8_7f", 1, 8'h7F, 8'h01, 1'b0, 1'b1);
    chk("w8_7f.S", 64'(b8.S), 64'h80);
    chk("w8_7f.OVF", 64'(b8.OVF), 64'd1);
    for (int i = 0; i < 20; i++)
      cyc("w8_rand", 1, 8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0));

    for (int i = 0; i < 5; i++) cyc("sat", 2, 8'd1, 8'd1, 1'b0, 1'b1);
    chk("sat.cnt", 64'(bs.carry_cnt), 64'd3);

    cyc("mid_pre", 0, 8'd0, 8'd1, 1'b0, 1'b1);
    rst_n = 1'b0;
    cyc("mid_rst", 0, 8'd1, 8'd1, 1'b1, 1'b1);
    chk("mid_rst.out_valid", 64'(b1.out_valid), 64'd0);
    rst_n = 1'b1;
    cyc("mid_post", 0, 8'd1, 8'd0, 1'b0, 1'b1);
    chk("mid_post.out_valid", 64'(b1.out_valid), 64'd1);
    chk("mid_post.S", 64'(b1.S), 64'd1);
    cyc("mid_idle", 0, 8'd0, 8'd0, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/full_adder_data.md
Name: full_adder_data

Overview:
- Registered, parameterizable ripple-carry adder built from single-bit full-adder cells, with carry-in and carry-out.
- Default WIDTH=1 reduces it to a classic 1-bit full adder with S/Cout outputs.
- Acts as the datapath leaf in the adder library (ripple-carry chain building block).
- Adds a valid strobe, status flags and a saturating carry-event counter so integration and debug can observe it.

Parameters:
- WIDTH, 1, operand/sum width in bits (legal range 1..64).
- CNT_W, 16, width of the carry-out event counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous active-low reset, sampled on rising clk.
- A  input  WIDTH  operand A, unsigned (also read as two's complement for the OVF flag).
- B  input  WIDTH  operand B.
- Cin  input  1  carry into bit 0.
- in_valid  input  1  operands valid this cycle.
- S  output  WIDTH  registered sum.
- Cout  output  1  registered carry out of the MSB.
- out_valid  output  1  S/Cout/flags updated this cycle.
- OVF  output  1  registered signed overflow: carry into MSB XOR carry out of MSB.
- ZERO  output  1  registered flag, 1 when S is all zeros.
- carry_cnt  output  CNT_W  saturating count of accepted additions with Cout=1.

Behaviour:
- Per bit i: s_i = a_i ^ b_i ^ c_i; c_(i+1) = (a_i & b_i) | (c_i & (a_i ^ b_i)); c_0 = Cin; Cout = c_WIDTH.
- The carry chain is purely combinational (ripple). It is registered once.
- Result is {Cout,S} = A + B + Cin, computed modulo 2^(WIDTH+1).
- Latency: exactly 1 clk. When in_valid=1 at edge k:
  - S, Cout, OVF and ZERO hold the result of the inputs sampled at edge k from edge k onward.
  - out_valid=1 for the cycle following edge k.
- When in_valid=0:
  - S, Cout, OVF and ZERO hold their previous values.
  - out_valid=0.
  - carry_cnt unchanged.
- For WIDTH=1, OVF = Cin ^ Cout.
- carry_cnt increments by 1 on each accepted addition (in_valid=1) producing Cout=1. It saturates at all-ones; no wrap.
- Reset: when rst_n=0 at a rising edge:
  - S=0, Cout=0, OVF=0, ZERO=1, out_valid=0, carry_cnt=0.
  - Reset overrides in_valid in the same cycle.
  - The inputs of a reset cycle are discarded.
- Reset asserted mid-stream drops the in-flight result. The first valid after reset deasserts produces output one cycle later as normal.
- Inputs (A, B, Cin) may change every cycle. There is no back-pressure.
- X/undriven inputs are not required to be handled when in_valid=0.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with in_valid=1, A=1, B=1, Cin=1 -> S=0, Cout=0, ZERO=1, out_valid=0, carry_cnt=0.
- WIDTH=1 exhaustive truth table: (A,B,Cin) presented one per cycle with in_valid=1:
  - 000 -> S=0, Cout=0
  - 100 -> S=1, Cout=0
  - 010 -> S=1, Cout=0
  - 110 -> S=0, Cout=1
  - 001 -> S=1, Cout=0
  - 101 -> S=0, Cout=1
  - 011 -> S=0, Cout=1
  - 111 -> S=1, Cout=1
  - Each result appears one cycle after its input; carry_cnt=4 at the end.
- Hold: drive in_valid=0 while changing A/B/Cin -> outputs frozen, out_valid=0, carry_cnt unchanged.
- WIDTH=8 ripple and flags:
  - A=0xFF, B=0x00, Cin=1 -> S=0x00, Cout=1, ZERO=1, OVF=0.
  - A=0x7F, B=0x01, Cin=0 -> S=0x80, Cout=0, OVF=1.
- Counter saturation: CNT_W=2, five consecutive A=1, B=1, Cin=0 (WIDTH=1) -> carry_cnt stops at 3.
- Reset mid-stream: valid input A=1, B=1, Cin=1 with rst_n=0 in the same cycle -> out_valid=0 next cycle. The next valid after reset releases produces its result one cycle later.
